// File: rtl/jk_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : jk_register_bank
// Purpose  : Bank of WIDTH independent rising-edge JK flip-flops with a shared
//            update enable, parallel load, programmable reset value, per-bit
//            registered change flags and an optional saturating counter of
//            edges on which q changed.
// Ports    : clk        - clock, all state updates on the rising edge
//            rst_n      - synchronous active-low reset
//            en         - JK update enable
//            load       - parallel load strobe (wins over en)
//            d          - parallel load data [WIDTH]
//            j, k       - per-bit J / K inputs [WIDTH]
//            clr_cnt    - synchronous clear of change_cnt
//            q          - registered state [WIDTH]
//            q_n        - ~q, combinational
//            changed    - per-bit flag, q[i] changed on the most recent edge
//            change_cnt - saturating count of edges on which q changed [CNT_W]
// Options  : JK_BANK_CHANGE_CNT_EN - when defined, builds the change counter;
//            otherwise change_cnt is tied to 0 and clr_cnt is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module jk_register_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] changed,
  output logic [CNT_W-1:0] change_cnt
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_changed;
  logic [WIDTH-1:0] w_jk;
  logic [WIDTH-1:0] w_q_next;
  logic             w_any_change;

  // Per-bit JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i = i + 1) begin : g_bit
      assign w_jk[i] = j[i] ? (k[i] ? ~r_q[i] : 1'b1)
                            : (k[i] ? 1'b0    : r_q[i]);
    end
  endgenerate

  // Load outranks the JK update; with neither active the bank holds.
  always_comb begin
    w_q_next = r_q;
    if (load) begin
      w_q_next = d;
    end else if (en) begin
      w_q_next = w_jk;
    end
  end

  assign w_any_change = |(w_q_next ^ r_q);

  // The reset edge never flags a change, even if RESET_VAL differs from q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q       <= RESET_VAL;
      r_changed <= {WIDTH{1'b0}};
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
    end
  end

`ifdef JK_BANK_CHANGE_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Clear beats increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_any_change && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign change_cnt = r_cnt;
`else
  // Counter not built: the port remains for a uniform interface.
  logic w_unused_cnt_inputs;
  assign w_unused_cnt_inputs = clr_cnt ^ w_any_change;
  assign change_cnt          = {CNT_W{1'b0}};
`endif

  assign q       = r_q;
  assign q_n     = ~r_q;
  assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_jk_register_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_register_bank
// Purpose  : Self-checking bench for jk_register_bank (WIDTH=8,
//            RESET_VAL=8'hA5, CNT_W=4) with directed scenarios and a
//            randomized run against a behavioural reference model.
// Options  : JK_BANK_CHANGE_CNT_EN - expected counter values follow the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_register_bank;

  localparam int         c_width = 8;
  localparam logic [7:0] c_rst   = 8'hA5;
  localparam int         c_cnt_w = 4;
`ifdef JK_BANK_CHANGE_CNT_EN
  localparam bit         c_cnt_en = 1'b1;
`else
  localparam bit         c_cnt_en = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, load, clr_cnt;
  logic [7:0] d, j, k;
  logic [7:0] q, q_n, changed;
  logic [3:0] change_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] m_q;
  logic [7:0] m_chg;
  int         m_cnt;

  jk_register_bank #(
    .WIDTH     (c_width),
    .RESET_VAL (c_rst),
    .CNT_W     (c_cnt_w)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .d          (d),
    .j          (j),
    .k          (k),
    .clr_cnt    (clr_cnt),
    .q          (q),
    .q_n        (q_n),
    .changed    (changed),
    .change_cnt (change_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_cnt();
    return c_cnt_en ? 4'(m_cnt) : 4'd0;
  endfunction

  // Behavioural view of one rising edge, following the operation rules.
  task automatic model_edge(input logic rn, input logic ld, input logic [7:0] dd,
                            input logic e, input logic [7:0] jj,
                            input logic [7:0] kk, input logic clr);
    logic [7:0] nq;
    if (!rn) begin
      m_q = c_rst; m_chg = 8'h00; m_cnt = 0;
      return;
    end
    nq = m_q;
    if (ld) nq = dd;
    else if (e) begin
      for (int b = 0; b < 8; b++) begin
        if (jj[b] == 1'b0 && kk[b] == 1'b1) nq[b] = 1'b0;
        else if (jj[b] == 1'b1 && kk[b] == 1'b0) nq[b] = 1'b1;
        else if (jj[b] == 1'b1 && kk[b] == 1'b1) nq[b] = ~m_q[b];
      end
    end
    m_chg = nq ^ m_q;
    if (clr) m_cnt = 0;
    else if (nq != m_q && m_cnt < 15) m_cnt = m_cnt + 1;
    m_q = nq;
  endtask

  // Apply inputs, advance the model and the DUT by one edge, sample at +1.
  task automatic drive(input logic rn, input logic ld, input logic [7:0] dd,
                       input logic e, input logic [7:0] jj,
                       input logic [7:0] kk, input logic clr);
    rst_n = rn; load = ld; d = dd; en = e; j = jj; k = kk; clr_cnt = clr;
    model_edge(rn, ld, dd, e, jj, kk, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 8'h3C, 1'b1, 8'hFF, 8'hFF, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    tests++; if (q !== 8'hA5) begin fails++; $display("FAIL reset_q: got %h want a5", q); end
    tests++; if (q_n !== 8'h5A) begin fails++; $display("FAIL reset_qn: got %h want 5a", q_n); end
    tests++; if (changed !== 8'h00) begin fails++; $display("FAIL reset_changed: got %h want 00", changed); end
    tests++; if (change_cnt !== 4'h0) begin fails++; $display("FAIL reset_cnt: got %h want 0", change_cnt); end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    tests++; if (q !== 8'hA5 || changed !== 8'h00) begin
      fails++; $display("FAIL reset_release: q %h chg %h want a5 00", q, changed);
    end
  endtask

  task automatic test_per_bit_codes();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 8'hF0, 8'h3C, 1'b0);
    tests++; if (q !== 8'hD1) begin fails++; $display("FAIL codes_q: got %h want d1", q); end
    tests++; if (q_n !== 8'h2E) begin fails++; $display("FAIL codes_qn: got %h want 2e", q_n); end
    tests++; if (changed !== 8'h74) begin fails++; $display("FAIL codes_changed: got %h want 74", changed); end
    tests++; if (change_cnt !== exp_cnt()) begin
      fails++; $display("FAIL codes_cnt: got %h want %h", change_cnt, exp_cnt());
    end
  endtask

  task automatic test_priority();
    logic [3:0] cnt_before;
    drive(1'b1, 1'b1, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0);
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL prio_load_q: got %h want 00", q); end
    tests++; if (changed !== m_chg) begin fails++; $display("FAIL prio_load_changed: got %h want %h", changed, m_chg); end
    cnt_before = exp_cnt();
    drive(1'b1, 1'b0, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0);
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL prio_hold_q: got %h want 00", q); end
    tests++; if (changed !== 8'h00) begin fails++; $display("FAIL prio_hold_changed: got %h want 00", changed); end
    tests++; if (change_cnt !== cnt_before) begin
      fails++; $display("FAIL prio_hold_cnt: got %h want %h", change_cnt, cnt_before);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0);
      tests++; if (q !== m_q || changed !== 8'hFF || change_cnt !== exp_cnt()) begin
        fails++; $display("FAIL sat_step%0d: q %h chg %h cnt %h want %h ff %h",
                          n, q, changed, change_cnt, m_q, exp_cnt());
      end
    end
    tests++; if (change_cnt !== (c_cnt_en ? 4'hF : 4'h0)) begin
      fails++; $display("FAIL sat_final: got %h want %h", change_cnt, c_cnt_en ? 4'hF : 4'h0);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1);
    tests++; if (change_cnt !== 4'h0 || changed !== 8'hFF) begin
      fails++; $display("FAIL sat_clear: cnt %h chg %h want 0 ff", change_cnt, changed);
    end
  endtask

  task automatic test_no_change_load();
    logic [3:0] cnt_before;
    drive(1'b1, 1'b1, 8'h96, 1'b0, 8'h00, 8'h00, 1'b0);
    cnt_before = exp_cnt();
    drive(1'b1, 1'b1, 8'h96, 1'b1, 8'hFF, 8'hFF, 1'b0);
    tests++; if (q !== 8'h96 || changed !== 8'h00) begin
      fails++; $display("FAIL nochg_load: q %h chg %h want 96 00", q, changed);
    end
    tests++; if (change_cnt !== cnt_before) begin
      fails++; $display("FAIL nochg_cnt: got %h want %h", change_cnt, cnt_before);
    end
    // Setting already-set bits flags nothing for them.
    drive(1'b1, 1'b0, 8'h00, 1'b1, 8'h97, 8'h00, 1'b0);
    tests++; if (q !== 8'h97 || changed !== 8'h01) begin
      fails++; $display("FAIL set_set: q %h chg %h want 97 01", q, changed);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b0);
    drive(1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1);
    tests++; if (q !== 8'hA5 || q_n !== 8'h5A) begin
      fails++; $display("FAIL midrst_q: q %h qn %h want a5 5a", q, q_n);
    end
    tests++; if (changed !== 8'h00 || change_cnt !== 4'h0) begin
      fails++; $display("FAIL midrst_flags: chg %h cnt %h want 00 0", changed, change_cnt);
    end
  endtask

  task automatic test_random();
    logic       rn, ld, e, clr;
    logic [7:0] dd, jj, kk;
    int         bad;
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      rn  = ($urandom_range(0, 15) != 0);
      ld  = ($urandom_range(0, 3) == 0);
      e   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      dd  = 8'($urandom);
      jj  = 8'($urandom);
      kk  = 8'($urandom);
      // Occasionally load the current value to exercise no-change edges.
      if ($urandom_range(0, 7) == 0) dd = m_q;
      drive(rn, ld, dd, e, jj, kk, clr);
      tests++;
      if (q !== m_q || q_n !== ~m_q || changed !== m_chg || change_cnt !== exp_cnt()) begin
        fails++;
        if (bad < 10) $display("FAIL rand%0d: q %h qn %h chg %h cnt %h want %h %h %h %h",
                               n, q, q_n, changed, change_cnt, m_q, ~m_q, m_chg, exp_cnt());
        bad++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
    d = 8'h00; j = 8'h00; k = 8'h00;
    m_q = c_rst; m_chg = 8'h00; m_cnt = 0;
    test_reset();
    test_per_bit_codes();
    test_priority();
    test_saturation();
    test_no_change_load();
    test_mid_reset();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
